// File: rtl/datapath_seq_if.sv
// datapath_seq_if: issue handshake and register-file port bundle for datapath_seq
interface datapath_seq_if #(parameter int n = 16);
   logic s, ready, write, done;
   logic [15:0] instr;
   logic [n-1:0] rf_data_out, data_in;
   logic [2:0] readnum, writenum, status;
   modport master (output s, instr, rf_data_out, input ready, readnum, writenum, write, data_in, status, done);
   modport slave (input s, instr, rf_data_out, output ready, readnum, writenum, write, data_in, status, done);
endinterface

// File: rtl/datapath_seq.sv
// datapath_seq: fetch/execute/write-back sequencer for an 8xn register file; DATAPATH_SEQ_SHIFT_EN compiles in the B-operand shifter
module datapath_seq #(parameter int n = 16) (
   input logic clk,
   input logic reset_n,
   datapath_seq_if.slave bus
);
   typedef enum logic [2:0] {IDLE, RDA, RDB, EXEC, WB} state_t;
   state_t state_q, state_d;
   logic [15:0] ir_q, ir_d;
   logic [n-1:0] a_q, a_d, b_q, b_d, c_q, c_d, data_in_q, data_in_d, diff, alu, shb, imm;
   logic [2:0] status_q, status_d, readnum_q, readnum_d, writenum_q, writenum_d, op;
   assign op = ir_q[15:13];
   assign imm = {{(n-8){ir_q[7]}}, ir_q[7:0]};
`ifdef DATAPATH_SEQ_SHIFT_EN
   assign shb = ir_q[4:3] == 2'b01 ? {bus.rf_data_out[n-2:0], 1'b0} :
                ir_q[4:3] == 2'b10 ? {1'b0, bus.rf_data_out[n-1:1]} :
                ir_q[4:3] == 2'b11 ? {bus.rf_data_out[n-1], bus.rf_data_out[n-1:1]} : bus.rf_data_out;
`else
   assign shb = bus.rf_data_out;
`endif
   always_comb begin
      state_d = state_q;
      ir_d = ir_q;
      a_d = a_q;
      b_d = b_q;
      c_d = c_q;
      status_d = status_q;
      readnum_d = readnum_q;
      writenum_d = writenum_q;
      data_in_d = data_in_q;
      diff = a_q - b_q;
      alu = op == 3'b001 ? b_q : op == 3'b010 ? a_q + b_q : op == 3'b100 ? a_q & b_q : op == 3'b101 ? ~b_q : diff;
      case (state_q)
         IDLE: if (bus.s && bus.instr[15:14] != 2'b11) begin
            ir_d = bus.instr;
            state_d = bus.instr[15:13] == 3'b000 ? WB :
                      (bus.instr[15:13] == 3'b001 || bus.instr[15:13] == 3'b101) ? RDB : RDA;
         end
         RDA: begin
            readnum_d = ir_q[12:10];
            a_d = bus.rf_data_out;
            state_d = RDB;
         end
         RDB: begin
            readnum_d = ir_q[2:0];
            b_d = shb;
            state_d = EXEC;
         end
         EXEC: begin
            c_d = alu;
            status_d = op == 3'b011 ? {diff == '0, diff[n-1], (a_q[n-1] != b_q[n-1]) & (diff[n-1] != a_q[n-1])} : status_q;
            state_d = op == 3'b011 ? IDLE : WB;
         end
         WB: begin
            writenum_d = op == 3'b000 ? ir_q[12:10] : ir_q[9:7];
            data_in_d = op == 3'b000 ? imm : c_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         ir_q <= '0;
         a_q <= '0;
         b_q <= '0;
         c_q <= '0;
         status_q <= '0;
         readnum_q <= '0;
         writenum_q <= '0;
         data_in_q <= '0;
      end else begin
         state_q <= state_d;
         ir_q <= ir_d;
         a_q <= a_d;
         b_q <= b_d;
         c_q <= c_d;
         status_q <= status_d;
         readnum_q <= readnum_d;
         writenum_q <= writenum_d;
         data_in_q <= data_in_d;
      end
   end
   // reset_n gates the outputs combinationally so a reset landing in WB suppresses the write
   assign bus.ready = state_q == IDLE;
   assign bus.readnum = reset_n ? readnum_d : '0;
   assign bus.writenum = reset_n ? writenum_d : '0;
   assign bus.data_in = reset_n ? data_in_d : '0;
   assign bus.write = reset_n & (state_q == WB);
   assign bus.done = reset_n & (state_q == WB || (state_q == EXEC && op == 3'b011));
   assign bus.status = status_q;
endmodule

// File: tb/tb_datapath_seq.sv
// tb_datapath_seq: directed table, multi-cycle corner sequences and randomized instructions against a reference model
module tb_datapath_seq;
`ifdef DATAPATH_SEQ_SHIFT_EN
   localparam bit sh_en = 1'b1;
`else
   localparam bit sh_en = 1'b0;
`endif
   typedef struct {
      int lat;
      logic wr;
      logic [2:0] wn;
      logic [15:0] wd;
      logic dn;
      logic rdy1;
      logic rdy;
      logic [2:0] st;
   } res_t;
   typedef struct {
      string nm;
      logic [15:0] ins, r0, r1;
      logic wr;
      logic [2:0] wn;
      logic [15:0] wd;
      int lat;
      logic [2:0] st;
   } vec_t;
   logic clk, reset_n, pl_en;
   logic [2:0] pl_idx;
   logic [15:0] pl_val;
   logic [15:0] rf [8];
   logic [15:0] mrf [8];
   logic [2:0] mstatus;
   int checks, errors;
   vec_t tbl [12];
   res_t r, e;
   datapath_seq_if #(.n(16)) bus();
   datapath_seq #(.n(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   assign bus.rf_data_out = rf[bus.readnum];
   always @(posedge clk)
      if (pl_en) rf[pl_idx] <= pl_val;
      else if (bus.write) rf[bus.writenum] <= bus.data_in;
   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, want);
      end
   endtask
   task automatic preload(input logic [2:0] i, input logic [15:0] v);
      pl_en = 1'b1;
      pl_idx = i;
      pl_val = v;
      @(posedge clk); #1;
      pl_en = 1'b0;
      mrf[i] = v;
   endtask
   task automatic issue(input logic [15:0] ins, output res_t o);
      int k;
      k = 0;
      while (!bus.ready && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("ready_before_issue", bus.ready, 1);
      o.lat = 0; o.wr = 0; o.wn = 0; o.wd = 0; o.dn = 0;
      bus.s = 1'b1;
      bus.instr = ins;
      @(posedge clk); #1;
      bus.s = 1'b0;
      o.rdy1 = bus.ready;
      for (int c = 1; c <= 6 && !o.dn; c++) begin
         if (bus.write) begin
            o.wr = 1; o.wn = bus.writenum; o.wd = bus.data_in; o.lat = c;
         end
         if (bus.done) begin
            o.dn = 1; o.lat = c;
         end
         @(posedge clk); #1;
      end
      o.rdy = bus.ready;
      o.st = bus.status;
   endtask
   task automatic cmp_res(input string t, input res_t a, input res_t w);
      check({t, " write"}, a.wr, w.wr);
      check({t, " writenum"}, a.wn, w.wn);
      check({t, " data_in"}, a.wd, w.wd);
      check({t, " done"}, a.dn, w.dn);
      check({t, " latency"}, a.lat, w.lat);
      check({t, " ready_after_accept"}, a.rdy1, w.rdy1);
      check({t, " ready_after_done"}, a.rdy, w.rdy);
      check({t, " status"}, a.st, w.st);
   endtask
   function automatic res_t model(input logic [15:0] ins);
      res_t m;
      logic [2:0] op, rd;
      logic [15:0] a, b, v;
      int d, iv;
      op = ins[15:13];
      rd = op == 3'd0 ? ins[12:10] : ins[9:7];
      a = mrf[ins[12:10]];
      b = mrf[ins[2:0]];
      if (sh_en)
         case (ins[4:3])
            2'd1: b = b << 1;
            2'd2: b = b >> 1;
            2'd3: b = (b >> 1) | (b & 16'h8000);
            default: ;
         endcase
      iv = $signed(ins[7:0]);
      v = 16'h0;
      case (op)
         3'd0: v = iv[15:0];
         3'd1: v = b;
         3'd2: v = a + b;
         3'd3: begin
            v = a - b;
            d = int'($signed(a)) - int'($signed(b));
            mstatus = {v == 16'h0, v[15], (d > 32767) || (d < -32768)};
         end
         3'd4: v = a & b;
         3'd5: v = ~b;
         default: ;
      endcase
      m.wr = op inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      m.lat = op == 3'd0 ? 1 : op inside {3'd1, 3'd3, 3'd5} ? 3 : op inside {3'd2, 3'd4} ? 4 : 0;
      m.dn = m.lat > 0;
      m.wn = m.wr ? rd : 3'd0;
      m.wd = m.wr ? v : 16'h0;
      if (m.wr) mrf[rd] = v;
      m.rdy1 = op >= 3'd6;
      m.rdy = 1'b1;
      m.st = mstatus;
      return m;
   endfunction
   initial begin
      checks = 0;
      errors = 0;
      pl_en = 1'b0;
      pl_idx = 3'd0;
      pl_val = 16'h0;
      bus.s = 1'b0;
      bus.instr = 16'h0;
      reset_n = 1'b0;
      mstatus = 3'b000;
      @(posedge clk); #1;
      check("rst write", bus.write, 0);
      check("rst done", bus.done, 0);
      check("rst readnum", bus.readnum, 0);
      check("rst writenum", bus.writenum, 0);
      check("rst data_in", bus.data_in, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      check("rst ready", bus.ready, 1);
      check("rst status", bus.status, 0);
      for (int i = 0; i < 8; i++) preload(3'(i), 16'h0);
      tbl[0]  = '{"movi_neg", 16'h0CFE, 16'h0000, 16'h0000, 1'b1, 3'd3, 16'hFFFE, 1, 3'b000};
      tbl[1]  = '{"add_lsl", 16'h4109, 16'h0005, 16'h0007, 1'b1, 3'd2, sh_en ? 16'h0013 : 16'h000C, 4, 3'b000};
      tbl[2]  = '{"mov", 16'h2281, 16'h0000, 16'hABCD, 1'b1, 3'd5, 16'hABCD, 3, 3'b000};
      tbl[3]  = '{"cmp_ovf", 16'h6001, 16'h8000, 16'h0001, 1'b0, 3'd0, 16'h0000, 3, 3'b001};
      tbl[4]  = '{"and_lsr", 16'h8311, 16'hFFFF, 16'h00F1, 1'b1, 3'd6, sh_en ? 16'h0078 : 16'h00F1, 4, 3'b001};
      tbl[5]  = '{"cmp_eq", 16'h6001, 16'h1234, 16'h1234, 1'b0, 3'd0, 16'h0000, 3, 3'b100};
      tbl[6]  = '{"mvn_asr", 16'hA219, 16'h0000, 16'h8000, 1'b1, 3'd4, sh_en ? 16'h3FFF : 16'h7FFF, 3, 3'b100};
      tbl[7]  = '{"ill_111", 16'hE000, 16'h0001, 16'h0002, 1'b0, 3'd0, 16'h0000, 0, 3'b100};
      tbl[8]  = '{"ill_110", 16'hC123, 16'h0001, 16'h0002, 1'b0, 3'd0, 16'h0000, 0, 3'b100};
      tbl[9]  = '{"movi_pos", 16'h1C7F, 16'h0000, 16'h0000, 1'b1, 3'd7, 16'h007F, 1, 3'b100};
      tbl[10] = '{"add_wrap", 16'h4100, 16'h8001, 16'h0000, 1'b1, 3'd2, 16'h0002, 4, 3'b100};
      tbl[11] = '{"cmp_neg", 16'h6001, 16'h0001, 16'h0002, 1'b0, 3'd0, 16'h0000, 3, 3'b010};
      for (int i = 0; i < 12; i++) begin
         preload(3'd0, tbl[i].r0);
         preload(3'd1, tbl[i].r1);
         issue(tbl[i].ins, r);
         e.wr = tbl[i].wr; e.wn = tbl[i].wn; e.wd = tbl[i].wd; e.lat = tbl[i].lat;
         e.dn = tbl[i].lat > 0; e.rdy1 = tbl[i].lat == 0; e.rdy = 1'b1; e.st = tbl[i].st;
         cmp_res(tbl[i].nm, r, e);
      end
      // s pulsed while busy must be ignored
      preload(3'd1, 16'h8000);
      preload(3'd7, 16'h5555);
      bus.s = 1'b1;
      bus.instr = 16'hA219;
      @(posedge clk); #1;
      bus.instr = 16'h1C01;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.s = 1'b0;
      check("busy write", bus.write, 1);
      check("busy writenum", bus.writenum, 4);
      check("busy data_in", bus.data_in, sh_en ? 16'h3FFF : 16'h7FFF);
      check("busy done", bus.done, 1);
      @(posedge clk); #1;
      check("busy ready_after", bus.ready, 1);
      check("busy no_extra_write", bus.write, 0);
      @(posedge clk); #1;
      check("busy r7_untouched", rf[7], 16'h5555);
      // illegal then MOVI with s held high
      bus.s = 1'b1;
      bus.instr = 16'hE000;
      @(posedge clk); #1;
      check("ill_b2b ready", bus.ready, 1);
      check("ill_b2b write", bus.write, 0);
      check("ill_b2b done", bus.done, 0);
      bus.instr = 16'h0CFE;
      @(posedge clk); #1;
      bus.s = 1'b0;
      check("ill_b2b movi write", bus.write, 1);
      check("ill_b2b movi writenum", bus.writenum, 3);
      check("ill_b2b movi data_in", bus.data_in, 16'hFFFE);
      check("ill_b2b movi done", bus.done, 1);
      @(posedge clk); #1;
      check("ill_b2b ready_after", bus.ready, 1);
      // reset arriving during WB of an ADD
      preload(3'd0, 16'h0005);
      preload(3'd1, 16'h0007);
      preload(3'd2, 16'hDEAD);
      bus.s = 1'b1;
      bus.instr = 16'h4109;
      @(posedge clk); #1;
      bus.s = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("rst_wb in_wb", bus.write, 1);
      reset_n = 1'b0;
      #1;
      check("rst_wb write_gated", bus.write, 0);
      check("rst_wb done_gated", bus.done, 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      check("rst_wb ready", bus.ready, 1);
      check("rst_wb status", bus.status, 0);
      @(posedge clk); #1;
      check("rst_wb r2_kept", rf[2], 16'hDEAD);
      mstatus = 3'b000;
      for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom));
      for (int i = 0; i < 150; i++) begin
         logic [15:0] ins;
         ins = 16'($urandom);
         e = model(ins);
         issue(ins, r);
         cmp_res($sformatf("rand%0d_%04h", i, ins), r, e);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) check($sformatf("final r%0d", i), rf[i], mrf[i]);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
